// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 timing, lock FSM states and pin helpers
package vga_timing_pkg;

   localparam int H_ACTIVE_DEF    = 640;
   localparam int H_TOTAL_DEF     = 800;
   localparam int H_ACT_START_DEF = 144;
   localparam int V_ACTIVE_DEF    = 480;
   localparam int V_TOTAL_DEF     = 525;
   localparam int V_ACT_START_DEF = 35;

   localparam logic [9:0] CNT_MAX   = 10'd1023;
   localparam logic [7:0] PINS_IDLE = 8'h88;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } lock_state_e;

   function automatic logic [9:0] sat_inc(input logic [9:0] v);
      return (v == CNT_MAX) ? v : v + 10'd1;
   endfunction

   // Tiny VGA Pmod pin order to {R1,R0,G1,G0,B1,B0}
   function automatic logic [5:0] pins_to_rgb(input logic [7:0] p);
      return {p[0], p[4], p[1], p[5], p[2], p[6]};
   endfunction

endpackage

// File: rtl/vga_frame_sig.sv
// rtl/vga_frame_sig.sv - per-frame rotate/XOR signature of the valid pixel stream
module vga_frame_sig
   import vga_timing_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pix_valid,
   input  logic [5:0]  pix_rgb,
   input  logic        clear,
   input  logic        capture,
   output logic        frame_done,
   output logic [15:0] frame_sig
);

   logic [15:0] acc_d, acc_q;
   logic [15:0] sig_d, sig_q;
   logic        done_d, done_q;

   always_comb begin
      acc_d  = acc_q;
      sig_d  = sig_q;
      done_d = capture;
      // A capture also restarts the accumulator for the frame that begins now
      if (clear || capture) begin
         acc_d = '0;
      end else if (pix_valid) begin
         acc_d = {acc_q[14:0], acc_q[15]} ^ {10'b0, pix_rgb};
      end
      if (capture) begin
         sig_d = acc_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q  <= '0;
         sig_q  <= '0;
         done_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         sig_q  <= sig_d;
         done_q <= done_d;
      end
   end

   assign frame_done = done_q;
   assign frame_sig  = sig_q;

endmodule

// File: rtl/vga_capture.sv
// rtl/vga_capture.sv - VGA pin capture with sync lock tracking and frame signature
module vga_capture
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE    = H_ACTIVE_DEF,
   parameter int H_TOTAL     = H_TOTAL_DEF,
   parameter int H_ACT_START = H_ACT_START_DEF,
   parameter int V_ACTIVE    = V_ACTIVE_DEF,
   parameter int V_TOTAL     = V_TOTAL_DEF,
   parameter int V_ACT_START = V_ACT_START_DEF
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  vga_in,
   output logic [5:0]  rgb,
   output logic [9:0]  hpos,
   output logic [9:0]  vpos,
   output logic        pixel_valid,
   output logic        locked,
   output logic        frame_done,
   output logic [15:0] frame_sig
);

   localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0]  H_LO   = 10'(H_ACT_START);
   localparam logic [10:0] H_HI   = 11'(H_ACT_START + H_ACTIVE);
   localparam logic [9:0]  V_LO   = 10'(V_ACT_START);
   localparam logic [10:0] V_HI   = 11'(V_ACT_START + V_ACTIVE);

   logic [7:0]  s1_d, s1_q, s1_prev_d, s1_prev_q;
   logic [9:0]  h_cnt_d, h_cnt_q, v_cnt_d, v_cnt_q;
   logic        frame_pend_d, frame_pend_q;
   lock_state_e state_d, state_q;
   logic        locked_d, locked_q;
   logic        pixel_valid_d, pixel_valid_q;
   logic [5:0]  rgb_d, rgb_q;
   logic [9:0]  hpos_d, hpos_q, vpos_d, vpos_q;

   logic hs_fall, vs_fall, frame_start;
   logic line_bad, frame_bad, h_sat, timing_err;
   logic h_in, v_in;
   logic sig_clear, sig_capture;

   // h_cnt_d/v_cnt_d are the coordinates of the pixel currently in stage 1
   always_comb begin
      s1_d      = vga_in;
      s1_prev_d = s1_q;
      hs_fall   = s1_prev_q[7] & ~s1_q[7];
      vs_fall   = s1_prev_q[3] & ~s1_q[3];
      frame_start = hs_fall & (frame_pend_q | vs_fall);

      h_cnt_d = hs_fall ? 10'd0 : sat_inc(h_cnt_q);
      v_cnt_d = v_cnt_q;
      if (frame_start) begin
         v_cnt_d = 10'd0;
      end else if (hs_fall) begin
         v_cnt_d = sat_inc(v_cnt_q);
      end

      frame_pend_d = frame_pend_q;
      if (frame_start) begin
         frame_pend_d = 1'b0;
      end else if (vs_fall) begin
         frame_pend_d = 1'b1;
      end

      line_bad   = hs_fall & (h_cnt_q != H_LAST);
      frame_bad  = frame_start & (v_cnt_q != V_LAST);
      h_sat      = (h_cnt_d == CNT_MAX);
      timing_err = line_bad | frame_bad | h_sat;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SEARCH: begin
            if (frame_start) state_d = VERIFY;
         end
         VERIFY: begin
            if (timing_err)       state_d = SEARCH;
            else if (frame_start) state_d = LOCKED;
         end
         LOCKED: begin
            if (timing_err) state_d = SEARCH;
         end
         default: state_d = SEARCH;
      endcase
      locked_d = (state_d == LOCKED);

      sig_clear   = ((state_d == SEARCH) && (state_q != SEARCH)) ||
                    ((state_q == VERIFY) && (state_d == LOCKED));
      sig_capture = frame_start && (state_q == LOCKED) && (state_d == LOCKED);
   end

   // Output stage uses the next lock state so an unlock blanks the same pixel
   always_comb begin
      h_in = (h_cnt_d >= H_LO) && ({1'b0, h_cnt_d} < H_HI);
      v_in = (v_cnt_d >= V_LO) && ({1'b0, v_cnt_d} < V_HI);
      pixel_valid_d = locked_d & h_in & v_in;
      rgb_d  = '0;
      hpos_d = '0;
      vpos_d = '0;
      if (pixel_valid_d) begin
         rgb_d  = pins_to_rgb(s1_q);
         hpos_d = h_cnt_d - H_LO;
         vpos_d = v_cnt_d - V_LO;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q          <= PINS_IDLE;
         s1_prev_q     <= PINS_IDLE;
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         frame_pend_q  <= 1'b0;
         pixel_valid_q <= 1'b0;
         rgb_q         <= '0;
         hpos_q        <= '0;
         vpos_q        <= '0;
      end else begin
         s1_q          <= s1_d;
         s1_prev_q     <= s1_prev_d;
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         frame_pend_q  <= frame_pend_d;
         pixel_valid_q <= pixel_valid_d;
         rgb_q         <= rgb_d;
         hpos_q        <= hpos_d;
         vpos_q        <= vpos_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= SEARCH;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         locked_q <= locked_d;
      end
   end

   vga_frame_sig u_frame_sig (
      .clk        (clk),
      .rst_n      (rst_n),
      .pix_valid  (pixel_valid_q),
      .pix_rgb    (rgb_q),
      .clear      (sig_clear),
      .capture    (sig_capture),
      .frame_done (frame_done),
      .frame_sig  (frame_sig)
   );

   assign rgb         = rgb_q;
   assign hpos        = hpos_q;
   assign vpos        = vpos_q;
   assign pixel_valid = pixel_valid_q;
   assign locked      = locked_q;

endmodule

// File: tb/tb_vga_capture.sv
// tb/tb_vga_capture.sv - directed bench for vga_capture on a reduced 16x8 raster
module tb_vga_capture;

   localparam int HT = 16;
   localparam int HS = 4;
   localparam int HA = 8;
   localparam int VT = 8;
   localparam int VS = 2;
   localparam int VA = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  vga_in;
   logic [5:0]  rgb;
   logic [9:0]  hpos, vpos;
   logic        pixel_valid, locked, frame_done;
   logic [15:0] frame_sig;

   int  checks = 0;
   int  failures = 0;
   int  cur_mode = 0;
   int  vcnt = 0;
   int  pix_bad = 0;
   int  done_cnt = 0;
   int  dbl_pulse = 0;
   bit  seen_first = 1'b0;
   bit  done_prev = 1'b0;
   bit  locked_prev = 1'b0;
   logic [9:0] first_h = '0, first_v = '0;
   logic [5:0] first_rgb = '0;
   time fs_t = 0, bad_hs_t = 0, lock_rise_t = 0, lock_fall_t = 0;

   vga_capture #(
      .H_ACTIVE(HA), .H_TOTAL(HT), .H_ACT_START(HS),
      .V_ACTIVE(VA), .V_TOTAL(VT), .V_ACT_START(VS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .vga_in(vga_in), .rgb(rgb), .hpos(hpos), .vpos(vpos),
      .pixel_valid(pixel_valid), .locked(locked), .frame_done(frame_done), .frame_sig(frame_sig)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [5:0] pix(input int mode, input int x, input int y);
      if (mode == 0) return 6'b110000;
      if (mode == 1) return (x == 0 && y == 0) ? 6'h01 : 6'h00;
      return 6'((x * 3 + y * 5 + 1) & 63);
   endfunction

   function automatic logic [15:0] model_sig(input int mode);
      logic [15:0] acc = '0;
      for (int y = 0; y < VA; y++)
         for (int x = 0; x < HA; x++)
            acc = {acc[14:0], acc[15]} ^ {10'b0, pix(mode, x, y)};
      return acc;
   endfunction

   function automatic logic [7:0] pins(input logic [5:0] c, input logic hs, input logic vs);
      return {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
   endfunction

   task automatic drive(input logic [7:0] v);
      vga_in = v;
      @(negedge clk);
   endtask

   task automatic send_line(input int len, input int y, input bit vs_whole, input int vs_from);
      logic [5:0] c;
      logic hs, vs;
      for (int h = 0; h < len; h++) begin
         hs = (h >= 2);
         vs = !(vs_whole || h >= vs_from);
         if (h >= HS && h < HS + HA && y >= VS && y < VS + VA) c = pix(cur_mode, h - HS, y - VS);
         else c = '0;
         drive(pins(c, hs, vs));
      end
   endtask

   task automatic send_frame(input int mode, input int nlines, input int bad_line, input bit early_vs);
      int len;
      cur_mode = mode;
      for (int l = 0; l < nlines; l++) begin
         len = (l == bad_line) ? HT - 1 : HT;
         if (l == 0) fs_t = $time;
         if (bad_line >= 0 && l == bad_line + 1) bad_hs_t = $time;
         send_line(len, l, l < 2, (early_vs && l == VT - 1) ? len - 3 : len + 1);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (pixel_valid) begin
            vcnt++;
            if (!seen_first) begin
               seen_first = 1'b1;
               first_h = hpos;
               first_v = vpos;
               first_rgb = rgb;
            end
            if (rgb !== pix(cur_mode, int'(hpos), int'(vpos)) || !locked) pix_bad++;
         end else if (rgb != 0 || hpos != 0 || vpos != 0) begin
            pix_bad++;
         end
         if (frame_done) begin
            done_cnt++;
            if (done_prev) dbl_pulse++;
         end
         done_prev = frame_done;
         if (locked && !locked_prev) lock_rise_t = $time;
         if (!locked && locked_prev) lock_fall_t = $time;
         locked_prev = locked;
      end
   end

   initial begin
      rst_n = 1'b0;
      vga_in = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_rgb", 32'(rgb), 0);
      check("rst_pos", 32'({hpos, vpos}), 0);
      check("rst_flags", 32'({pixel_valid, locked, frame_done}), 0);
      check("rst_sig", 32'(frame_sig), 0);

      vga_in = 8'h88;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) drive(8'h88);
      check("idle_unlocked", 32'(locked), 0);

      send_frame(0, VT, -1, 1'b0);
      check("f1_unlocked", 32'(locked), 0);
      vcnt = 0;
      send_frame(0, VT, -1, 1'b0);
      check("lock_latency", 32'(lock_rise_t - fs_t), 20);
      check("f2_locked", 32'(locked), 1);
      check("first_pixel", 32'({first_h, first_v, first_rgb}), 32'({10'd0, 10'd0, 6'b110000}));
      check("valid_count", 32'(vcnt), HA * VA);
      check("no_done_yet", 32'(done_cnt), 0);

      send_frame(2, VT, -1, 1'b0);
      check("sig_solid", 32'(frame_sig), 32'(model_sig(0)));
      check("done_cnt_1", 32'(done_cnt), 1);
      send_frame(1, VT, -1, 1'b0);
      check("sig_pattern", 32'(frame_sig), 32'(model_sig(2)));
      send_frame(0, VT, -1, 1'b0);
      check("sig_single", 32'(frame_sig), 32'h8000);
      check("done_cnt_3", 32'(done_cnt), 3);

      send_frame(0, VT, 3, 1'b0);
      check("bad_line_drop", 32'(lock_fall_t - bad_hs_t), 20);
      check("bad_line_unlocked", 32'(locked), 0);
      send_frame(0, VT, -1, 1'b0);
      check("verify_unlocked", 32'(locked), 0);
      send_frame(0, VT, -1, 1'b0);
      check("relock", 32'(locked), 1);
      check("no_partial_done", 32'(done_cnt), 4);

      drive(pins(6'h00, 1'b0, 1'b1));
      drive(pins(6'h00, 1'b0, 1'b1));
      for (int i = 2; i < 1100; i++) begin
         drive(pins(6'h00, 1'b1, 1'b1));
         if (i == 1000) check("hold_still_locked", 32'(locked), 1);
      end
      check("sat_unlock", 32'(locked), 0);
      check("sat_no_pixel", 32'(pixel_valid), 0);

      send_frame(0, VT, -1, 1'b0);
      send_frame(2, VT, -1, 1'b1);
      check("relock_after_sat", 32'(locked), 1);
      send_frame(0, VT, -1, 1'b0);
      check("pend_frame_start", 32'(done_cnt), 5);
      check("pend_sig", 32'(frame_sig), 32'(model_sig(2)));
      check("pend_locked", 32'(locked), 1);

      send_frame(0, 3, -1, 1'b0);
      check("mid_frame_locked", 32'(locked), 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_outs", 32'({rgb, hpos, vpos, pixel_valid, locked, frame_done}), 0);
      check("mid_rst_sig", 32'(frame_sig), 0);
      @(negedge clk);
      vga_in = 8'h88;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) drive(8'h88);
      send_frame(0, VT, -1, 1'b0);
      check("rst_reacq_verify", 32'(locked), 0);
      send_frame(0, VT, -1, 1'b0);
      check("rst_reacq_locked", 32'(locked), 1);

      check("done_total", 32'(done_cnt), 6);
      check("done_one_cycle", 32'(dbl_pulse), 0);
      check("pixel_stream", 32'(pix_bad), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
